// File: rtl/atomrvcore_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// atomrvcore_fetch_ctrl
// Fetch sequencer between the next-PC logic and instruction memory. Owns the
// fetch PC and runs a req/gnt/rvalid handshake with at most one request
// outstanding. Returned words are buffered with their PCs and handed to decode
// over valid/ready. Redirects flush everything in flight and restart fetching.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target parks the fetcher in
//               TRAP (no requests, fetch_misalign_o=1, if_pc_o=raw target)
//               until an aligned redirect or reset.
//   undefined : target low bits are silently cleared, fetch_misalign_o=0.
//
// Ports
//   clk_i, PCrst_i        clock, async active-low reset
//   imem_req_o/addr_o     fetch request and word-aligned address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i response (1+ cycles after gnt)
//   redirect_i/pc_i       control-flow change and its target
//   if_valid_o/ready_i    decode handshake on the buffer head
//   if_instr_o/if_pc_o    head instruction and its PC (0 while empty)
//   fetch_misalign_o      misaligned-redirect flag
//
// state | meaning
// IDLE  | one cycle after reset release, responses ignored
// REQ   | request presented at fetch_pc until granted
// WAIT  | one request outstanding, push its response
// DRAIN | request from before a redirect outstanding, drop its response
// HOLD  | buffer full, wait for decode to pop
// TRAP  | misaligned redirect target, fetching stopped (macro builds only)
// -----------------------------------------------------------------------------
module atomrvcore_fetch_ctrl #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 PCrst_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i,
  output logic                 if_valid_o,
  input  logic                 if_ready_i,
  output logic [DATAWIDTH-1:0] if_instr_o,
  output logic [DATAWIDTH-1:0] if_pc_o,
  output logic                 fetch_misalign_o
);

  localparam int unsigned   PW       = $clog2(BUF_DEPTH);
  localparam int unsigned   CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_t;

  state_t               r_state, w_state_next;
  logic [DATAWIDTH-1:0] r_fetch_pc, r_req_pc;
  logic [DATAWIDTH-1:0] r_buf_pc    [BUF_DEPTH];
  logic [DATAWIDTH-1:0] r_buf_instr [BUF_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count, w_count_next;
  logic                 w_req, w_grant, w_redirect, w_push, w_pop, w_in_flight;
  logic [DATAWIDTH-1:0] w_target;
  logic [DATAWIDTH-1:0] w_head_pc;

  assign w_target   = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
  // Requests are only presented when a push cannot overflow the buffer.
  assign w_req      = (r_state == S_REQ) && (r_count < LP_DEPTH);
  assign w_grant    = w_req && imem_gnt_i;
  assign w_redirect = redirect_i && (r_state != S_IDLE);
  assign w_push     = (r_state == S_WAIT) && imem_rvalid_i && !w_redirect;
  assign w_pop      = if_valid_o && if_ready_i && !w_redirect;
  // A response is still owed after this edge: must be drained, not pushed.
  assign w_in_flight = (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid_i)
                       || w_grant;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                 r_misalign;
  logic [DATAWIDTH-1:0] r_trap_pc;
  logic                 w_redirect_mis;

  assign w_redirect_mis = (redirect_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_misalign <= 1'b0;
      r_trap_pc  <= '0;
    end else if (w_redirect) begin
      r_misalign <= w_redirect_mis;
      r_trap_pc  <= redirect_pc_i;
    end
  end

  assign fetch_misalign_o = r_misalign;
  assign if_pc_o          = r_misalign ? r_trap_pc : w_head_pc;
`else
  logic w_unused_lsbs;
  assign w_unused_lsbs    = ^redirect_pc_i[1:0];
  assign fetch_misalign_o = 1'b0;
  assign if_pc_o          = w_head_pc;
`endif

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   if (w_grant) w_state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid_i) w_state_next = (w_count_next < LP_DEPTH) ? S_REQ : S_HOLD;
      S_HOLD:  if (r_count < LP_DEPTH) w_state_next = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      S_DRAIN: if (imem_rvalid_i) w_state_next = r_misalign ? S_TRAP : S_REQ;
      S_TRAP:  w_state_next = S_TRAP;
`else
      S_DRAIN: if (imem_rvalid_i) w_state_next = S_REQ;
`endif
      default: w_state_next = S_IDLE;
    endcase
    if (w_redirect) begin
      if (w_in_flight) begin
        w_state_next = S_DRAIN;
`ifdef FETCH_MISALIGN_TRAP_EN
      end else if (w_redirect_mis) begin
        w_state_next = S_TRAP;
`endif
      end else begin
        w_state_next = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
      end else if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + DATAWIDTH'(4);
      end
      if (w_grant) begin
        r_req_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_req_pc;
      r_buf_instr[r_wr_ptr] <= imem_rdata_i;
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign if_valid_o  = (r_count != '0);
  assign w_head_pc   = if_valid_o ? r_buf_pc[r_rd_ptr] : '0;
  assign if_instr_o  = if_valid_o ? r_buf_instr[r_rd_ptr] : '0;

endmodule

// File: tb/tb_atomrvcore_fetch_ctrl.sv
module tb_atomrvcore_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        PCrst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        fetch_misalign_o;

  always #5 clk_i = ~clk_i;

  atomrvcore_fetch_ctrl #(
    .DATAWIDTH(32),
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .PCrst_i         (PCrst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_instr_o      (if_instr_o),
    .if_pc_o         (if_pc_o),
    .fetch_misalign_o(fetch_misalign_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the buffer is a queue of delivered {pc, instr}; memory is
  // a single pending response slot with a latency countdown.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] model_pc, inflight_pc, trap_pc;
  bit          inflight, squashed, model_mis, expect_req_next;
  int          inflight_cnt;
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] tgt, input int lat);
    bit          rv, req_s, val_s, grant, pop;
    logic [31:0] addr_s, pc_s, exp_pc, exp_ins;
    exp_pc  = model_mis ? trap_pc : ((q.size() != 0) ? q[0].pc : 32'h0);
    exp_ins = (q.size() != 0) ? q[0].ins : 32'h0;
    chk("if_valid", if_valid_o, q.size() != 0);
    chk("if_pc", if_pc_o, exp_pc);
    chk("if_instr", if_instr_o, exp_ins);
    chk("misalign", fetch_misalign_o, model_mis);
    if (expect_req_next) chk("req_after_redirect", imem_req_o, 1'b1);
    if (imem_req_o === 1'b1) begin
      chk("req_addr", imem_addr_o, model_pc);
      chk("issue_rule", (!inflight && (q.size() < DEPTH) && !model_mis), 1'b1);
    end
    rv = 1'b0;
    if (inflight) begin
      inflight_cnt--;
      if (inflight_cnt == 0) rv = 1'b1;
    end
    imem_gnt_i    = gnt;
    if_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? instr_of(inflight_pc) : $urandom;
    req_s  = (imem_req_o === 1'b1);
    val_s  = (if_valid_o === 1'b1);
    addr_s = imem_addr_o;
    pc_s   = if_pc_o;
    grant  = req_s && gnt;
    pop    = val_s && rdy;
    @(posedge clk_i);
    cyc++;
    if (grant) begin
      grant_log.push_back(addr_s);
      grant_cyc.push_back(cyc);
    end
    if (redir) begin
      q.delete();
      if (grant) begin
        inflight = 1'b1; inflight_cnt = lat; squashed = 1'b1;
      end else if (inflight && rv) begin
        inflight = 1'b0;
      end else if (inflight) begin
        squashed = 1'b1;
      end
      model_pc = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      model_mis = (tgt[1:0] != 2'b00);
      trap_pc   = tgt;
`endif
      expect_req_next = !inflight && !model_mis;
    end else begin
      if (pop && q.size() != 0) begin
        pop_log.push_back(pc_s);
        void'(q.pop_front());
      end
      if (rv) begin
        if (!squashed) q.push_back('{inflight_pc, instr_of(inflight_pc)});
        inflight = 1'b0;
      end
      if (grant) begin
        inflight = 1'b1; inflight_cnt = lat; squashed = 1'b0;
        inflight_pc = model_pc;
        model_pc = model_pc + 32'd4;
      end
      expect_req_next = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    PCrst_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", if_valid_o, 1'b0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_misalign", fetch_misalign_o, 1'b0);
    @(negedge clk_i);
    q.delete(); grant_log.delete(); grant_cyc.delete(); pop_log.delete();
    model_pc = 32'h0; model_mis = 1'b0; trap_pc = 32'h0; expect_req_next = 1'b0;
    // A stale response from before reset lands in the IDLE cycle.
    inflight = 1'b1; inflight_cnt = 1; squashed = 1'b1; inflight_pc = 32'hDEAD_0000;
    PCrst_i = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    expect_req_next = 1'b1;
  endtask

  task automatic run_grants(input int n, input bit gnt, input bit rdy, input int lat, input string tag);
    int k = 0;
    while (grant_log.size() < n && k < 40) begin
      step(gnt, rdy, 1'b0, 32'h0, lat);
      k++;
    end
    chk(tag, grant_log.size() >= n, 1'b1);
  endtask

  task automatic run_pops(input int n, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < 40) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      k++;
    end
    chk(tag, pop_log.size() >= n, 1'b1);
  endtask

  initial begin
    int np;
    int ng;

    // Zero-wait memory: one fetch every two cycles, in order.
    do_reset();
    run_grants(3, 1'b1, 1'b1, 1, "tput_timeout");
    if (grant_log.size() >= 3) begin
      chk("tput_addr0", grant_log[0], 32'h0);
      chk("tput_addr1", grant_log[1], 32'h4);
      chk("tput_addr2", grant_log[2], 32'h8);
      chk("tput_gap01", grant_cyc[1] - grant_cyc[0], 32'd2);
      chk("tput_gap12", grant_cyc[2] - grant_cyc[1], 32'd2);
    end
    run_pops(2, "tput_pop_timeout");
    if (pop_log.size() >= 2) begin
      chk("tput_pop0", pop_log[0], 32'h0);
      chk("tput_pop1", pop_log[1], 32'h4);
    end

    // Decode stalled: buffer fills to depth, then fetching stops.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    chk("full_grants", grant_log.size(), 32'd2);
    chk("full_valid", if_valid_o, 1'b1);
    chk("full_head_pc", if_pc_o, 32'h0);
    chk("full_req", imem_req_o, 1'b0);
    run_grants(3, 1'b1, 1'b1, 3, "resume_timeout");
    if (grant_log.size() >= 3) chk("resume_addr", grant_log[2], 32'h8);
    if (pop_log.size() >= 2) begin
      chk("resume_pop0", pop_log[0], 32'h0);
      chk("resume_pop1", pop_log[1], 32'h4);
    end

    // Redirect while waiting on 0x8: its response is drained and dropped.
    np = pop_log.size();
    step(1'b1, 1'b1, 1'b1, 32'h100, 1);
    chk("drain_flush_valid", if_valid_o, 1'b0);
    run_grants(4, 1'b1, 1'b1, 1, "drain_timeout");
    if (grant_log.size() >= 4) chk("drain_new_addr", grant_log[3], 32'h100);
    run_pops(np + 1, "drain_pop_timeout");
    if (pop_log.size() > np) chk("drain_pop_pc", pop_log[np], 32'h100);

    // Ungranted request withdrawn by a redirect.
    do_reset();
    run_grants(3, 1'b1, 1'b1, 1, "ungnt_timeout");
    step(1'b0, 1'b1, 1'b0, 32'h0, 1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1);
    chk("ungnt_req", imem_req_o, 1'b1);
    chk("ungnt_addr", imem_addr_o, 32'hC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1);
    np = pop_log.size();
    step(1'b0, 1'b1, 1'b1, 32'h200, 1);
    chk("ungnt_redir_req", imem_req_o, 1'b1);
    chk("ungnt_redir_addr", imem_addr_o, 32'h200);
    chk("ungnt_grants", grant_log.size(), 32'd3);
    run_pops(np + 1, "ungnt_pop_timeout");
    if (pop_log.size() > np) chk("ungnt_pop_pc", pop_log[np], 32'h200);

    // Redirect coinciding with push and pop; target wraps past the top.
    do_reset();
    run_grants(2, 1'b1, 1'b0, 1, "wrap_setup_timeout");
    chk("wrap_pre_valid", if_valid_o, 1'b1);
    np = pop_log.size();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
    chk("wrap_flush_valid", if_valid_o, 1'b0);
    chk("wrap_req", imem_req_o, 1'b1);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    run_grants(4, 1'b1, 1'b1, 1, "wrap_timeout");
    if (grant_log.size() >= 4) begin
      chk("wrap_addr_top", grant_log[2], 32'hFFFF_FFFC);
      chk("wrap_addr_zero", grant_log[3], 32'h0);
    end
    run_pops(np + 1, "wrap_pop_timeout");
    if (pop_log.size() > np) chk("wrap_pop_pc", pop_log[np], 32'hFFFF_FFFC);

    // Misaligned redirect target.
    do_reset();
    run_grants(1, 1'b1, 1'b1, 1, "mis_setup_timeout");
    step(1'b1, 1'b1, 1'b1, 32'h102, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", fetch_misalign_o, 1'b1);
    chk("mis_pc", if_pc_o, 32'h102);
    chk("mis_req", imem_req_o, 1'b0);
    ng = grant_log.size();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("mis_no_grant", grant_log.size(), ng);
    step(1'b1, 1'b1, 1'b1, 32'h104, 1);
    chk("mis_clear_flag", fetch_misalign_o, 1'b0);
    chk("mis_clear_req", imem_req_o, 1'b1);
    chk("mis_clear_addr", imem_addr_o, 32'h104);
`else
    chk("mis_flag", fetch_misalign_o, 1'b0);
    chk("mis_req", imem_req_o, 1'b1);
    chk("mis_addr", imem_addr_o, 32'h100);
`endif

    // Randomized traffic against the model, including a mid-run reset.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      bit          rd;
      if (i == 2000) do_reset();
      t  = $urandom;
      t[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      rd = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rd, t, $urandom_range(1, 4));
    end
    chk("random_progress", pop_log.size() > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
